// File: rtl/sys_ctrl_fsm_pkg.sv
// Shared types and constants for the system control FSM: CPU control states,
// stop-cause and mode codes, and the probe ROM end marker.
package sys_ctrl_fsm_pkg;

  typedef enum logic [1:0] {
    COM_RST = 2'b00,
    COM_RUN = 2'b01,
    COM_STP = 2'b10
  } com_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_SINGLE = 3'd1,
    CAUSE_STEP   = 3'd2,
    CAUSE_INTR   = 3'd3,
    CAUSE_HALT   = 3'd4,
    CAUSE_BREAK  = 3'd5
  } stop_cause_e;

  typedef enum logic [1:0] {
    MODE_FREE   = 2'd0,
    MODE_INTR   = 2'd1,
    MODE_SINGLE = 2'd2,
    MODE_STEP   = 2'd3
  } run_mode_e;

  localparam logic [3:0] MEM_END = 4'hF;

endpackage

// File: rtl/sys_ctrl_fsm_if.sv
// CPU and probe-ROM side signals of the system control FSM.
// master = the control FSM, slave = the CPU core / probe ROM side.
interface sys_ctrl_fsm_if #(
  parameter int ADDR_W  = 12,
  parameter int PROBE_W = 32,
  parameter int STEP_W  = 8
);
  import sys_ctrl_fsm_pkg::*;

  logic               insn_end;
  logic               intr_detected;
  logic               halted;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  bp_addr;
  logic               bp_en;
  logic [PROBE_W-1:0] probe_info;
  com_state_e         cpu_state;
  logic [ADDR_W-1:0]  com_addr_reg;
  logic [ADDR_W-1:0]  probe_idx;
  logic [STEP_W-1:0]  run_cnt;
  logic [2:0]         stop_cause;

  modport master (
    input  insn_end, intr_detected, halted, pc, bp_addr, bp_en, probe_info,
    output cpu_state, com_addr_reg, probe_idx, run_cnt, stop_cause
  );

  modport slave (
    output insn_end, intr_detected, halted, pc, bp_addr, bp_en, probe_info,
    input  cpu_state, com_addr_reg, probe_idx, run_cnt, stop_cause
  );

endinterface

// File: rtl/sys_ctrl_fsm_key_edge_det.sv
// Two-flop synchroniser and falling-edge pulse generator for active-low keys.
// Registers reset to 0 so a key held down through reset produces no edge.
module key_edge_det #(
  parameter int N_KEYS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] fall
);

  logic [N_KEYS-1:0] sync1, sync2, prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Pulse is combinational off the registers so the FSM acts on the 3rd edge.
  assign fall = prev & ~sync2;

endmodule

// File: rtl/sys_ctrl_fsm.sv
// System control FSM: pushbutton run/stop/reset control, step/breakpoint stop
// conditions and the stop-mode address browser. Breakpoint: SYS_BREAKPOINT_EN.
module sys_ctrl_fsm
  import sys_ctrl_fsm_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int PROBE_W = 32,
  parameter int STEP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        KEY,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step_count,
  sys_ctrl_fsm_if.master    bus
);

  logic [3:0]        kp;
  com_state_e        state;
  stop_cause_e       cause;
  stop_cause_e       stop_code;
  logic              stop_hit;
  logic              bp_hit;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [STEP_W-1:0] cnt_reg;
  logic [STEP_W-1:0] step_load;
  logic [3:0]        probe_hdr;
  logic [ADDR_W-1:0] probe_addr;
  logic              unused_probe;

  key_edge_det #(.N_KEYS(4)) u_key_edge_det (
    .clk   (clk),
    .reset (reset),
    .key_n (KEY),
    .fall  (kp)
  );

`ifdef SYS_BREAKPOINT_EN
  // PC is compared after the instruction completes, so the CPU stops before it.
  assign bp_hit = bus.bp_en & bus.insn_end & (bus.pc == bus.bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{bus.pc, bus.bp_addr, bus.bp_en};
  assign bp_hit    = 1'b0;
`endif

  assign step_load    = (step_count == '0) ? STEP_W'(1) : step_count;
  assign probe_hdr    = bus.probe_info[PROBE_W-1 -: 4];
  assign probe_addr   = bus.probe_info[PROBE_W-5 -: ADDR_W];
  assign unused_probe = ^bus.probe_info[PROBE_W-5-ADDR_W:0];

  always_comb begin
    stop_hit  = 1'b1;
    stop_code = CAUSE_NONE;
    if (bp_hit)
      stop_code = CAUSE_BREAK;
    else if (bus.halted && kp[1])
      stop_code = CAUSE_HALT;
    else if (mode == MODE_INTR && bus.intr_detected)
      stop_code = CAUSE_INTR;
    else if (mode == MODE_STEP && bus.insn_end && cnt_reg == STEP_W'(1))
      stop_code = CAUSE_STEP;
    else if (mode == MODE_SINGLE)
      stop_code = CAUSE_SINGLE;
    else
      stop_hit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COM_RST;
      cause    <= CAUSE_NONE;
      addr_reg <= '0;
      idx_reg  <= '0;
      cnt_reg  <= STEP_W'(1);
    end else begin
      unique case (state)
        COM_RST: begin
          addr_reg <= '0;
          idx_reg  <= '0;
          if (kp[0]) begin
            state   <= COM_RUN;
            cnt_reg <= step_load;
          end else if (kp[1]) begin
            state <= COM_STP;
          end
        end

        COM_RUN: begin
          if (mode == MODE_STEP && bus.insn_end && cnt_reg > STEP_W'(1))
            cnt_reg <= cnt_reg - STEP_W'(1);
          if (kp[0]) begin
            state    <= COM_RST;
            cause    <= CAUSE_NONE;
            addr_reg <= '0;
            idx_reg  <= '0;
          end else if (stop_hit) begin
            state <= COM_STP;
            cause <= stop_code;
          end
        end

        COM_STP: begin
          if (kp[0]) begin
            state    <= COM_RST;
            cause    <= CAUSE_NONE;
            addr_reg <= '0;
            idx_reg  <= '0;
          end else begin
            if (kp[1]) begin
              state   <= COM_RUN;
              cnt_reg <= step_load;
            end
            // Halted CPU browses the probe ROM; otherwise a manual counter.
            if (bus.halted) begin
              addr_reg <= probe_addr;
              if (kp[2] || probe_hdr == MEM_END)
                idx_reg <= '0;
              else if (kp[3])
                idx_reg <= idx_reg + ADDR_W'(1);
            end else begin
              if (kp[2])
                addr_reg <= '0;
              else if (kp[3])
                addr_reg <= addr_reg + ADDR_W'(1);
            end
          end
        end

        default: state <= COM_RST;
      endcase
    end
  end

  assign bus.cpu_state    = state;
  assign bus.stop_cause   = cause;
  assign bus.com_addr_reg = addr_reg;
  assign bus.probe_idx    = idx_reg;
  assign bus.run_cnt      = cnt_reg;

endmodule

// File: tb/tb_sys_ctrl_fsm.sv
// Scoreboard testbench for sys_ctrl_fsm: expectations are queued with the
// stimulus and checked against DUT outputs after each step settles.
module tb_sys_ctrl_fsm;
  import sys_ctrl_fsm_pkg::*;

  localparam int ADDR_W  = 12;
  localparam int PROBE_W = 32;
  localparam int STEP_W  = 8;

  typedef enum int {SEL_STATE, SEL_ADDR, SEL_IDX, SEL_CNT, SEL_CAUSE} sel_e;

  typedef struct {
    string tag;
    sel_e  sel;
    int    exp;
  } sb_entry_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        KEY;
  logic [1:0]        mode;
  logic [STEP_W-1:0] step_count;

  sb_entry_t sbQ[$];
  int        checks = 0;
  int        errors = 0;
  int        bpCause;

  logic [PROBE_W-1:0] rom [0:3];

  sys_ctrl_fsm_if #(.ADDR_W(ADDR_W), .PROBE_W(PROBE_W), .STEP_W(STEP_W)) bus ();

  sys_ctrl_fsm #(.ADDR_W(ADDR_W), .PROBE_W(PROBE_W), .STEP_W(STEP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .KEY        (KEY),
    .mode       (mode),
    .step_count (step_count),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Probe ROM model with one cycle of read latency.
  always_ff @(posedge clk)
    bus.probe_info <= rom[bus.probe_idx[1:0]];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpect(input string tag, input sel_e sel, input int exp);
    sb_entry_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sbQ.push_back(e);
  endtask

  task automatic drainScoreboard();
    sb_entry_t   e;
    logic [31:0] obs;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      case (e.sel)
        SEL_STATE: obs = 32'(bus.cpu_state);
        SEL_ADDR:  obs = 32'(bus.com_addr_reg);
        SEL_IDX:   obs = 32'(bus.probe_idx);
        SEL_CNT:   obs = 32'(bus.run_cnt);
        default:   obs = 32'(bus.stop_cause);
      endcase
      checkOutput(e.tag, obs, e.exp);
    end
  endtask

  // Press the keys in mask for one cycle and wait until the FSM has reacted.
  task automatic applyStimulus(input logic [3:0] mask);
    KEY = ~mask;
    tick(1);
    KEY = 4'hF;
    tick(2);
  endtask

  task automatic pulseInsn();
    bus.insn_end = 1'b1;
    tick(1);
    bus.insn_end = 1'b0;
  endtask

  initial begin
    rom[0] = {4'h0, 12'hFFF, 16'h0};
    rom[1] = {4'h0, 12'h123, 16'h0};
    rom[2] = {4'hF, 12'hABC, 16'h0};
    rom[3] = {4'hF, 12'h000, 16'h0};
`ifdef SYS_BREAKPOINT_EN
    bpCause = 5;
`else
    bpCause = 3;
`endif
    reset = 1'b1;
    KEY = 4'hF;
    mode = 2'd0;
    step_count = 8'd1;
    bus.insn_end = 1'b0;
    bus.intr_detected = 1'b0;
    bus.halted = 1'b0;
    bus.pc = '0;
    bus.bp_addr = '0;
    bus.bp_en = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(3);

    pushExpect("rst_state", SEL_STATE, COM_RST);
    pushExpect("rst_addr", SEL_ADDR, 0);
    pushExpect("rst_idx", SEL_IDX, 0);
    pushExpect("rst_cnt", SEL_CNT, 1);
    pushExpect("rst_cause", SEL_CAUSE, 0);
    drainScoreboard();

    // Key latency: held KEY[0] reaches RUN on the 3rd edge only.
    KEY[0] = 1'b0;
    tick(2);
    pushExpect("k0_edge2", SEL_STATE, COM_RST);
    drainScoreboard();
    tick(1);
    pushExpect("k0_edge3", SEL_STATE, COM_RUN);
    drainScoreboard();
    KEY[0] = 1'b1;
    tick(2);
    pushExpect("k0_release", SEL_STATE, COM_RUN);
    drainScoreboard();
    applyStimulus(4'b0001);
    pushExpect("k0_back_rst", SEL_STATE, COM_RST);
    pushExpect("k0_rst_addr", SEL_ADDR, 0);
    drainScoreboard();

    // Step N instructions.
    mode = 2'd3;
    step_count = 8'd3;
    applyStimulus(4'b0001);
    pushExpect("step_run", SEL_STATE, COM_RUN);
    pushExpect("step_cnt3", SEL_CNT, 3);
    drainScoreboard();
    pulseInsn();
    pushExpect("step_cnt2", SEL_CNT, 2);
    pushExpect("step_run2", SEL_STATE, COM_RUN);
    drainScoreboard();
    pulseInsn();
    pushExpect("step_cnt1", SEL_CNT, 1);
    pushExpect("step_run1", SEL_STATE, COM_RUN);
    drainScoreboard();
    pulseInsn();
    pushExpect("step_stp", SEL_STATE, COM_STP);
    pushExpect("step_cause", SEL_CAUSE, 2);
    pushExpect("step_cnt_floor", SEL_CNT, 1);
    drainScoreboard();

    step_count = 8'd0;
    applyStimulus(4'b0010);
    pushExpect("step0_run", SEL_STATE, COM_RUN);
    pushExpect("step0_cnt", SEL_CNT, 1);
    drainScoreboard();
    pulseInsn();
    pushExpect("step0_stp", SEL_STATE, COM_STP);
    drainScoreboard();

    // Breakpoint and interrupt in the same cycle.
    mode = 2'd1;
    bus.bp_en = 1'b1;
    bus.bp_addr = 12'h010;
    bus.pc = 12'h010;
    applyStimulus(4'b0010);
    pushExpect("bp_run", SEL_STATE, COM_RUN);
    drainScoreboard();
    bus.insn_end = 1'b1;
    bus.intr_detected = 1'b1;
    tick(1);
    bus.insn_end = 1'b0;
    bus.intr_detected = 1'b0;
    bus.bp_en = 1'b0;
    pushExpect("bp_stp", SEL_STATE, COM_STP);
    pushExpect("bp_cause", SEL_CAUSE, bpCause);
    drainScoreboard();

    // Single cycle: RUN lasts exactly one cycle.
    mode = 2'd2;
    applyStimulus(4'b0010);
    pushExpect("single_run", SEL_STATE, COM_RUN);
    drainScoreboard();
    tick(1);
    pushExpect("single_stp", SEL_STATE, COM_STP);
    pushExpect("single_cause", SEL_CAUSE, 1);
    drainScoreboard();

    // Manual browser wrap and clear.
    mode = 2'd0;
    bus.halted = 1'b1;
    tick(1);
    bus.halted = 1'b0;
    pushExpect("brw_load_fff", SEL_ADDR, 12'hFFF);
    drainScoreboard();
    applyStimulus(4'b1000);
    pushExpect("brw_wrap", SEL_ADDR, 0);
    drainScoreboard();
    applyStimulus(4'b1000);
    pushExpect("brw_inc", SEL_ADDR, 1);
    drainScoreboard();
    applyStimulus(4'b1100);
    pushExpect("brw_clr_wins", SEL_ADDR, 0);
    drainScoreboard();

    // Halted probe walk.
    bus.halted = 1'b1;
    tick(1);
    pushExpect("prb_addr0", SEL_ADDR, 12'hFFF);
    drainScoreboard();
    applyStimulus(4'b1000);
    pushExpect("prb_idx1", SEL_IDX, 1);
    drainScoreboard();
    tick(2);
    pushExpect("prb_addr1", SEL_ADDR, 12'h123);
    drainScoreboard();
    applyStimulus(4'b1000);
    pushExpect("prb_idx2", SEL_IDX, 2);
    drainScoreboard();
    tick(2);
    pushExpect("prb_end_idx", SEL_IDX, 0);
    pushExpect("prb_addr2", SEL_ADDR, 12'hABC);
    drainScoreboard();
    tick(2);
    pushExpect("prb_addr_back", SEL_ADDR, 12'hFFF);
    drainScoreboard();
    applyStimulus(4'b1000);
    pushExpect("prb_idx_again", SEL_IDX, 1);
    drainScoreboard();

    // Halted plus run/stop key while running.
    applyStimulus(4'b0010);
    pushExpect("halt_run", SEL_STATE, COM_RUN);
    drainScoreboard();
    applyStimulus(4'b0010);
    pushExpect("halt_stp", SEL_STATE, COM_STP);
    pushExpect("halt_cause", SEL_CAUSE, 4);
    drainScoreboard();
    bus.halted = 1'b0;

    applyStimulus(4'b0001);
    pushExpect("stp_to_rst", SEL_STATE, COM_RST);
    pushExpect("rst_cause_clr", SEL_CAUSE, 0);
    pushExpect("rst_idx_clr", SEL_IDX, 0);
    pushExpect("rst_addr_clr", SEL_ADDR, 0);
    drainScoreboard();

    // Both keys together from RST: run wins.
    applyStimulus(4'b0011);
    pushExpect("dual_key_run", SEL_STATE, COM_RUN);
    drainScoreboard();

    // Reset mid-RUN overrides a pending key.
    KEY[1] = 1'b0;
    reset = 1'b1;
    tick(1);
    pushExpect("midrun_reset", SEL_STATE, COM_RST);
    pushExpect("midrun_cnt", SEL_CNT, 1);
    drainScoreboard();
    reset = 1'b0;
    tick(4);
    pushExpect("held_key_no_edge", SEL_STATE, COM_RST);
    drainScoreboard();
    KEY = 4'hF;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
